// File: rtl/seq_event_monitor.sv
// Event statistics for a sequence detector: saturating event count, last/min
// gap between accepted pulses, and a sticky threshold interrupt.
module seq_event_monitor #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seq_detected,
  input  logic             enable,
  input  logic             clear_cnt,
  input  logic             clr_irq,
  input  logic [CNT_W-1:0] threshold,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic [GAP_W-1:0] last_gap,
  output logic [GAP_W-1:0] min_gap,
  output logic             gap_valid,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GAP_W-1:0] GAP_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01
  } state_t;

  state_t           state, state_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             overflow_nxt;
  logic [GAP_W-1:0] last_gap_nxt;
  logic [GAP_W-1:0] min_gap_nxt;
  logic             gap_valid_nxt;
  logic             irq_nxt;
  logic             accepted;

  assign accepted = seq_detected & enable & ~clear_cnt;

  // Next-state and next-statistics logic; clear_cnt discards a coincident pulse.
  always_comb begin
    state_nxt     = state;
    gap_cnt_nxt   = gap_cnt;
    count_nxt     = count;
    overflow_nxt  = overflow;
    last_gap_nxt  = last_gap;
    min_gap_nxt   = min_gap;
    gap_valid_nxt = gap_valid;
    irq_nxt       = irq;

    if (clr_irq) begin
      irq_nxt = 1'b0;
    end

    if (clear_cnt) begin
      state_nxt     = IDLE;
      gap_cnt_nxt   = '0;
      count_nxt     = '0;
      overflow_nxt  = 1'b0;
      last_gap_nxt  = '0;
      min_gap_nxt   = GAP_MAX;
      gap_valid_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          gap_cnt_nxt = '0;
          if (accepted) begin
            state_nxt   = TRACK;
            gap_cnt_nxt = GAP_W'(1);
          end
        end
        TRACK: begin
          if (accepted) begin
            last_gap_nxt  = gap_cnt;
            gap_valid_nxt = 1'b1;
            gap_cnt_nxt   = GAP_W'(1);
            if (gap_cnt < min_gap) begin
              min_gap_nxt = gap_cnt;
            end
          end else if (gap_cnt != GAP_MAX) begin
            gap_cnt_nxt = gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state_nxt   = IDLE;
          gap_cnt_nxt = '0;
        end
      endcase

      // Interrupt fires only on a real increment landing on the threshold; set beats clr_irq.
      if (accepted) begin
        if (count == CNT_MAX) begin
          overflow_nxt = 1'b1;
        end else begin
          count_nxt = count + CNT_W'(1);
          if ((threshold != '0) && (count_nxt == threshold)) begin
            irq_nxt = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      last_gap  <= '0;
      min_gap   <= GAP_MAX;
      gap_valid <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state     <= state_nxt;
      gap_cnt   <= gap_cnt_nxt;
      count     <= count_nxt;
      overflow  <= overflow_nxt;
      last_gap  <= last_gap_nxt;
      min_gap   <= min_gap_nxt;
      gap_valid <= gap_valid_nxt;
      irq       <= irq_nxt;
    end
  end

endmodule

// File: tb/tb_seq_event_monitor.sv
// Self-checking bench for seq_event_monitor: vector table, directed corner
// sequences and randomized traffic against an event-time reference model.
module tb_seq_event_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       seq_detected, enable, clear_cnt, clr_irq;
  logic [7:0] threshold;
  logic [3:0] threshold4;

  logic [7:0] count, last_gap, min_gap;
  logic       overflow, gap_valid, irq;
  logic [3:0] count4;
  logic [7:0] last_gap4, min_gap4;
  logic       overflow4, gap_valid4, irq4;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  always #5 clk = ~clk;

  seq_event_monitor #(.CNT_W(8), .GAP_W(8)) dut (
    .clk(clk), .reset(reset), .seq_detected(seq_detected), .enable(enable),
    .clear_cnt(clear_cnt), .clr_irq(clr_irq), .threshold(threshold),
    .count(count), .overflow(overflow), .last_gap(last_gap), .min_gap(min_gap),
    .gap_valid(gap_valid), .irq(irq)
  );

  seq_event_monitor #(.CNT_W(4), .GAP_W(8)) dut4 (
    .clk(clk), .reset(reset), .seq_detected(seq_detected), .enable(enable),
    .clear_cnt(clear_cnt), .clr_irq(clr_irq), .threshold(threshold4),
    .count(count4), .overflow(overflow4), .last_gap(last_gap4), .min_gap(min_gap4),
    .gap_valid(gap_valid4), .irq(irq4)
  );

  // Reference model: remembers the cycle of the last accepted pulse, gaps are time differences.
  typedef struct {
    int cmax;
    bit have_prev;
    int prev;
    int cnt;
    bit ovf;
    int lgap;
    int mgap;
    bit gv;
    bit irq;
  } mdl_t;

  mdl_t m8, m4;

  function automatic mdl_t mreset(int cmax);
    mdl_t m;
    m.cmax = cmax; m.have_prev = 0; m.prev = 0; m.cnt = 0; m.ovf = 0;
    m.lgap = 0; m.mgap = 255; m.gv = 0; m.irq = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t mi, bit sd, bit en, bit clr, bit ci, int thr, int t);
    mdl_t m = mi;
    bit set_irq = 0;
    if (clr) begin
      m.have_prev = 0; m.cnt = 0; m.ovf = 0; m.lgap = 0; m.mgap = 255; m.gv = 0;
    end else if (sd && en) begin
      if (m.have_prev) begin
        int g;
        g = t - m.prev;
        if (g > 255) g = 255;
        m.lgap = g;
        if (g < m.mgap) m.mgap = g;
        m.gv = 1;
      end
      m.have_prev = 1;
      m.prev = t;
      if (m.cnt == m.cmax) m.ovf = 1;
      else begin
        m.cnt++;
        if (thr != 0 && m.cnt == thr) set_irq = 1;
      end
    end
    if (set_irq) m.irq = 1;
    else if (ci) m.irq = 0;
    return m;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic check_models();
    chk("count",     int'(count),     m8.cnt);
    chk("overflow",  int'(overflow),  int'(m8.ovf));
    chk("last_gap",  int'(last_gap),  m8.lgap);
    chk("min_gap",   int'(min_gap),   m8.mgap);
    chk("gap_valid", int'(gap_valid), int'(m8.gv));
    chk("irq",       int'(irq),       int'(m8.irq));
    chk("count4",    int'(count4),    m4.cnt);
    chk("overflow4", int'(overflow4), int'(m4.ovf));
    chk("last_gap4", int'(last_gap4), m4.lgap);
    chk("min_gap4",  int'(min_gap4),  m4.mgap);
    chk("gap_valid4",int'(gap_valid4),int'(m4.gv));
    chk("irq4",      int'(irq4),      int'(m4.irq));
  endtask

  // Drive inputs away from the edge, advance one clock, update models, check.
  task automatic step(input bit sd, input bit en, input bit clr, input bit ci);
    seq_detected = sd; enable = en; clear_cnt = clr; clr_irq = ci;
    @(posedge clk);
    cyc++;
    m8 = mstep(m8, sd, en, clr, ci, int'(threshold), cyc);
    m4 = mstep(m4, sd, en, clr, ci, int'(threshold4), cyc);
    #1;
    check_models();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    seq_detected = 0; enable = 1; clear_cnt = 0; clr_irq = 0;
    m8 = mreset(255);
    m4 = mreset(15);
    #2;
    check_models();
    reset = 1'b0;
  endtask

  typedef struct {
    bit sd, en, clr, ci;
    int cnt, irq, gv, lgap, mgap;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    seq_detected = 0; enable = 1; clear_cnt = 0; clr_irq = 0;
    threshold = 8'd0; threshold4 = 4'd0;

    // Table: threshold=2, hand-derived expectations
    tbl[0] = '{0, 1, 0, 0,  0, 0, 0, 0, 255};
    tbl[1] = '{1, 1, 0, 0,  1, 0, 0, 0, 255};
    tbl[2] = '{0, 1, 0, 0,  1, 0, 0, 0, 255};
    tbl[3] = '{1, 1, 0, 0,  2, 1, 1, 2, 2};
    tbl[4] = '{1, 1, 0, 1,  3, 0, 1, 1, 1};
    tbl[5] = '{1, 0, 0, 0,  3, 0, 1, 1, 1};
    tbl[6] = '{1, 1, 0, 0,  4, 0, 1, 2, 1};
    tbl[7] = '{1, 1, 1, 0,  0, 0, 0, 0, 255};
    tbl[8] = '{1, 1, 0, 0,  1, 0, 0, 0, 255};
    tbl[9] = '{0, 1, 0, 0,  1, 0, 0, 0, 255};

    #3;
    do_reset();
    chk("rst_count", int'(count), 0);
    chk("rst_min_gap", int'(min_gap), 255);
    threshold = 8'd2;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].sd, tbl[i].en, tbl[i].clr, tbl[i].ci);
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
      chk($sformatf("tbl%0d_irq", i), int'(irq), tbl[i].irq);
      chk($sformatf("tbl%0d_gap_valid", i), int'(gap_valid), tbl[i].gv);
      chk($sformatf("tbl%0d_last_gap", i), int'(last_gap), tbl[i].lgap);
      chk($sformatf("tbl%0d_min_gap", i), int'(min_gap), tbl[i].mgap);
    end

    // Pulses at cycles 10, 15, 27
    threshold = 8'd0;
    do_reset();
    for (int c = 0; c <= 27; c++) begin
      step(c == 10 || c == 15 || c == 27, 1, 0, 0);
      if (c == 10) chk("gap_valid_after_first", int'(gap_valid), 0);
    end
    chk("a_count", int'(count), 3);
    chk("a_last_gap", int'(last_gap), 12);
    chk("a_min_gap", int'(min_gap), 5);
    chk("a_gap_valid", int'(gap_valid), 1);

    // threshold=3, four pulses 6 apart, then clr_irq
    threshold = 8'd3;
    do_reset();
    for (int c = 0; c <= 18; c++) begin
      step(c % 6 == 0, 1, 0, 0);
      if (c == 6)  chk("b_irq_after_2nd", int'(irq), 0);
      if (c == 12) chk("b_irq_after_3rd", int'(irq), 1);
    end
    chk("b_irq_after_4th", int'(irq), 1);
    step(0, 1, 0, 1);
    chk("b_irq_cleared", int'(irq), 0);
    do_reset();
    for (int c = 0; c <= 12; c++) step(c % 6 == 0, 1, 0, c == 12);
    chk("b_set_beats_clr", int'(irq), 1);

    // 4-bit counter saturation and overflow
    threshold = 8'd0; threshold4 = 4'd5;
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      step(1, 1, 0, 0);
      if (k == 15) begin
        chk("c_count4_15", int'(count4), 15);
        chk("c_ovf4_15", int'(overflow4), 0);
      end
      if (k == 16) begin
        chk("c_count4_16", int'(count4), 15);
        chk("c_ovf4_16", int'(overflow4), 1);
      end
    end
    chk("c_count4_17", int'(count4), 15);
    step(1, 1, 1, 0);
    chk("c_clr_count4", int'(count4), 0);
    chk("c_clr_ovf4", int'(overflow4), 0);
    chk("c_clr_min_gap4", int'(min_gap4), 255);
    chk("c_clr_irq4_kept", int'(irq4), 1);
    threshold4 = 4'd0;

    // Gap saturation, and a disabled pulse inside a gap
    do_reset();
    for (int c = 0; c <= 300; c++) step(c == 0 || c == 300, 1, 0, 0);
    chk("d_last_gap_sat", int'(last_gap), 255);
    do_reset();
    for (int c = 0; c <= 12; c++) step(c == 0 || c == 5 || c == 12, c != 5, 0, 0);
    chk("d_count_en", int'(count), 2);
    chk("d_last_gap_en", int'(last_gap), 12);

    // Async reset mid-TRACK with count=4, irq=1
    threshold = 8'd4;
    do_reset();
    for (int c = 0; c <= 10; c++) step(c % 3 == 1, 1, 0, 0);
    chk("f_pre_count", int'(count), 4);
    chk("f_pre_irq", int'(irq), 1);
    #2 reset = 1'b1;
    #1;
    chk("f_rst_count", int'(count), 0);
    chk("f_rst_irq", int'(irq), 0);
    chk("f_rst_min_gap", int'(min_gap), 255);
    chk("f_rst_last_gap", int'(last_gap), 0);
    chk("f_rst_gap_valid", int'(gap_valid), 0);
    m8 = mreset(255);
    m4 = mreset(15);
    #1 reset = 1'b0;
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("f_first_after_rst_gap", int'(last_gap), 2);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 3) begin
        threshold  = 8'($urandom_range(0, 20));
        threshold4 = 4'($urandom_range(0, 15));
      end
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 85,
           $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/seq_event_monitor.md
Name: seq_event_monitor

Overview:
- Downstream consumer of the non-overlapping 10101 Mealy detector's registered `seq_detected` pulse.
- Counts detection events with saturation and measures clock gaps between consecutive detections: last gap and minimum gap.
- Raises a sticky interrupt when the event count reaches a programmable threshold.
- Sits between the detector and the status/register logic; all outputs are registered.

Parameters:
- CNT_W, 8, width of the event counter and the threshold.
- GAP_W, 8, width of the gap counter, `last_gap` and `min_gap`.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- seq_detected  input  1  detection pulse from the detector; sampled every rising edge.
- enable  input  1  1 = accept pulses; 0 = ignore pulses (gap timer keeps running).
- clear_cnt  input  1  synchronous clear of statistics.
- clr_irq  input  1  synchronous clear of `irq`.
- threshold  input  CNT_W  count value that sets `irq`; 0 disables irq.
- count  output  CNT_W  accepted-event count, saturating.
- overflow  output  1  sticky; set on an accepted pulse while `count` is all-ones.
- last_gap  output  GAP_W  cycles between the two most recent accepted pulses.
- min_gap  output  GAP_W  smallest gap since reset/clear; all-ones when none is recorded.
- gap_valid  output  1  1 once at least one gap has been recorded.
- irq  output  1  sticky threshold interrupt.

Behaviour:
- Decided: one clock; reset is asynchronous and active-high. Ports are named clk and reset.
- Reset values:
  - state=IDLE, gap_cnt=0, count=0, overflow=0.
  - last_gap=0, min_gap=all-ones, gap_valid=0, irq=0.
- Accepted pulse: `seq_detected`=1 AND `enable`=1 AND `clear_cnt`=0.
- Latency: every output reflects an accepted pulse on the edge that samples it, visible the cycle after the pulse.
- State machine (2 states):
  - IDLE: no accepted pulse since reset/clear. `gap_cnt` is held at 0. An accepted pulse moves to TRACK with gap_cnt<=1.
  - TRACK, cycle with no accepted pulse: gap_cnt<=gap_cnt+1, saturating at all-ones (no wrap).
  - TRACK, accepted pulse:
    - last_gap<=gap_cnt, min_gap<=min(min_gap,gap_cnt), gap_valid<=1, gap_cnt<=1.
    - Pulses at cycles t and t+k give gap=k.
  - No other transitions; illegal state encoding recovers to IDLE.
- Count: each accepted pulse does count<=count+1, saturating at all-ones.
  - A pulse at all-ones leaves count unchanged and sets overflow<=1.
  - overflow stays set until clear_cnt or reset.
- irq:
  - Set when an accepted pulse makes count+1 == threshold (non-saturated increment) and threshold!=0.
  - Cleared by clr_irq. Set and clr_irq in the same cycle: set wins.
  - clear_cnt does not affect irq.
- clear_cnt=1:
  - Next edge: state=IDLE, gap_cnt=0, count=0, overflow=0, last_gap=0, min_gap=all-ones, gap_valid=0.
  - A coincident pulse is discarded (clear wins).
- enable=0: pulses are ignored for count, gaps and irq. The gap timer still advances in TRACK, so a later gap includes the disabled interval.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronous). First pulse after release is treated as first-ever.
- Changing `threshold` does not retro-fire irq; only the transition on an accepted pulse sets it.

Test Plan:
- Reset, then pulses at cycles 10, 15 and 27 (enable=1) -> count=3, last_gap=12, min_gap=5, gap_valid=1 after cycle 27; gap_valid=0 after cycle 10 only.
- threshold=3, four pulses 6 cycles apart -> irq rises the cycle after the 3rd pulse and stays 1 after the 4th. clr_irq for 1 cycle -> irq=0. clr_irq coincident with the 3rd pulse (in a fresh run) -> irq=1.
- CNT_W=4, 17 accepted pulses -> count=15 after the 15th pulse and stays 15; overflow=1 after the 16th. clear_cnt -> count=0, overflow=0, min_gap=8'hFF, irq unchanged.
- Pulses at cycles 0 and 300 with GAP_W=8 -> last_gap=255 (saturated). enable=0 during a pulse at cycle 5 between pulses at 0 and 12 -> count=2, last_gap=12.
- Pulse coincident with clear_cnt -> count=0, state IDLE. Next pulse is treated as first: gap_valid stays 0.
- Assert reset between edges mid-TRACK with count=4, irq=1 -> all outputs go to reset values without waiting for clk.
